// File: rtl/guess_key_player.sv
// guess_key_player: replays a packed code of 2-bit symbols as key pulses,
// then an enter pulse, the way a player would press the buttons.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   start  - playback request, sampled only while idle
//   code   - packed symbols; slot k = code[2k+1:2k], slot 0 played first
//   len    - number of symbols to play (MIN_LEN..MAX_LEN)
//   abort  - (GUESS_KEY_ABORT_EN only) cancel playback in progress
//   key    - one-hot key pulses, key[0]=I1 .. key[3]=I4
//   enter  - enter pulse after the last symbol
//   busy   - high while playback is in progress
//   done   - 1-cycle pulse when playback completes
//   err    - 1-cycle pulse on a rejected start (or an abort)
//
// Build option: define GUESS_KEY_ABORT_EN to add the abort input.

`timescale 1ns/1ps

module guess_key_player #(
    parameter int MAX_LEN   = 7,
    parameter int MIN_LEN   = 4,
    parameter int PRESS_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*MAX_LEN-1:0]   code,
    input  logic [3:0]             len,
`ifdef GUESS_KEY_ABORT_EN
    input  logic                   abort,
`endif
    output logic [3:0]             key,
    output logic                   enter,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int PG_MAX = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
    localparam int CW     = (PG_MAX > 1) ? $clog2(PG_MAX) : 1;

    localparam logic [CW-1:0] P_LAST = CW'(PRESS_CYC - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        ENTER,
        DONE
    } state_t;

    state_t                 state;
    logic [2*MAX_LEN-1:0]   code_q;
    logic [3:0]             len_q;
    logic [2:0]             idx;
    logic [CW-1:0]          cnt;

    logic       len_ok;
    logic       last;
    logic [2:0] nidx;
    logic [1:0] nsym;
    logic       abort_hit;

    assign len_ok = (len >= 4'(MIN_LEN)) && (len <= 4'(MAX_LEN));
    assign last   = ({1'b0, idx} == (len_q - 4'd1));
    assign nidx   = idx + 3'd1;
    // Next slot is only read when it exists (idx < len-1 <= MAX_LEN-1).
    assign nsym   = code_q[{nidx, 1'b0} +: 2];

`ifdef GUESS_KEY_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    function automatic logic [3:0] sym_key(input logic [1:0] s);
        logic [3:0] k;
        k = 4'b0000;
        unique case (s)
            2'b00: k = 4'b0001;
            2'b01: k = 4'b0010;
            2'b10: k = 4'b0100;
            2'b11: k = 4'b1000;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            code_q <= '0;
            len_q  <= '0;
            idx    <= '0;
            cnt    <= '0;
            key    <= '0;
            enter  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort_hit && state != IDLE) begin
                // Cancel: drop outputs at once, report via err, not done.
                state <= IDLE;
                key   <= '0;
                enter <= 1'b0;
                busy  <= 1'b0;
                err   <= 1'b1;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (len_ok) begin
                                code_q <= code;
                                len_q  <= len;
                                idx    <= '0;
                                cnt    <= '0;
                                key    <= sym_key(code[1:0]);
                                busy   <= 1'b1;
                                state  <= PRESS;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    PRESS: begin
                        if (cnt == P_LAST) begin
                            cnt   <= '0;
                            key   <= '0;
                            state <= GAP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    GAP: begin
                        if (cnt == G_LAST) begin
                            cnt <= '0;
                            if (last) begin
                                enter <= 1'b1;
                                state <= ENTER;
                            end else begin
                                idx   <= nidx;
                                key   <= sym_key(nsym);
                                state <= PRESS;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ENTER: begin
                        if (cnt == P_LAST) begin
                            cnt   <= '0;
                            enter <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        key   <= '0;
                        enter <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_key_player.sv
// tb_guess_key_player: table-driven playback vectors plus hand-written
// sequences for rejected starts, reset mid-press and abort.

`timescale 1ns/1ps

module tb_guess_key_player;

    localparam int P  = 4;
    localparam int G  = 4;
    localparam int PG = P + G;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] code;
    logic [3:0]  len;
    logic        abort;
    logic [3:0]  key;
    logic        enter;
    logic        busy;
    logic        done;
    logic        err;

    int n_pass;
    int n_total;

    guess_key_player dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .code  (code),
        .len   (len),
`ifdef GUESS_KEY_ABORT_EN
        .abort (abort),
`endif
        .key   (key),
        .enter (enter),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [13:0] code;
        logic [3:0]  len;
        bit          exp_err;
        int          exp_done;
        bit          restart;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] k;
        k = 4'b0001 << s;
        return k;
    endfunction

    // Expected key for cycle c after the start edge, from the timing rule.
    function automatic logic [3:0] exp_key(input logic [13:0] cd,
                                           input int n, input int c);
        int k;
        int ph;
        logic [1:0] s;
        k  = (c - 1) / PG;
        ph = (c - 1) % PG;
        if (k < n && ph < P) begin
            s = cd[2*k +: 2];
            return onehot(s);
        end
        return 4'b0000;
    endfunction

    function automatic logic exp_enter(input int n, input int c);
        return ((c - 1) / PG == n) && ((c - 1) % PG < P);
    endfunction

    task automatic play_check(input vec_t v);
        int n;
        n = int'(v.len);
        code  = v.code;
        len   = v.len;
        start = 1'b1;
        step();
        start = 1'b0;
        code  = ~v.code;
        len   = 4'd5;
        if (v.exp_err) begin
            chk({v.name, ".err"}, 1, 32'(err), 32'd1);
            chk({v.name, ".key"}, 1, 32'(key), 32'd0);
            chk({v.name, ".enter"}, 1, 32'(enter), 32'd0);
            chk({v.name, ".busy"}, 1, 32'(busy), 32'd0);
            step();
            chk({v.name, ".err_clr"}, 2, 32'(err), 32'd0);
            chk({v.name, ".busy2"}, 2, 32'(busy), 32'd0);
            return;
        end
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            chk({v.name, ".key"}, c, 32'(key), 32'(exp_key(v.code, n, c)));
            chk({v.name, ".enter"}, c, 32'(enter), 32'(exp_enter(n, c)));
            chk({v.name, ".done"}, c, 32'(done), 32'(c == v.exp_done));
            chk({v.name, ".busy"}, c, 32'(busy), 32'(c <= v.exp_done));
            chk({v.name, ".err"}, c, 32'(err), 32'd0);
            if (v.restart && c == 10) begin
                start = 1'b1;
                code  = 14'h1555;
                len   = 4'd4;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        vec_t rv;
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        start   = 1'b0;
        code    = '0;
        len     = '0;
        abort   = 1'b0;

        vecs[0] = '{"seq0123",  14'h00E4, 4'd4, 1'b0, 37, 1'b0};
        vecs[1] = '{"all10x7",  14'h2AAA, 4'd7, 1'b0, 61, 1'b0};
        vecs[2] = '{"len3",     14'h00E4, 4'd3, 1'b1, 0,  1'b0};
        vecs[3] = '{"len8",     14'h00E4, 4'd8, 1'b1, 0,  1'b0};
        vecs[4] = '{"restart",  14'h00E4, 4'd4, 1'b0, 37, 1'b1};
        vecs[5] = '{"all11x5",  14'h03FF, 4'd5, 1'b0, 45, 1'b0};

        #2;
        chk("rst.key", 0, 32'(key), 32'd0);
        chk("rst.enter", 0, 32'(enter), 32'd0);
        chk("rst.busy", 0, 32'(busy), 32'd0);
        chk("rst.done", 0, 32'(done), 32'd0);
        chk("rst.err", 0, 32'(err), 32'd0);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            play_check(vecs[i]);
            step();
        end

        // Reset during the slot-1 press: outputs must drop without a clock.
        code  = 14'h00E4;
        len   = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        chk("mid.key1", 10, 32'(key), 32'h2);
        #1;
        reset = 1'b1;
        #1;
        chk("mid.rst_key", 10, 32'(key), 32'd0);
        chk("mid.rst_busy", 10, 32'(busy), 32'd0);
        chk("mid.rst_enter", 10, 32'(enter), 32'd0);
        step();
        reset = 1'b0;
        step();
        rv = '{"fresh", 14'h00E7, 4'd4, 1'b0, 37, 1'b0};
        play_check(rv);
        step();

`ifdef GUESS_KEY_ABORT_EN
        // Abort in idle: nothing happens.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab.idle_err", 1, 32'(err), 32'd0);
        chk("ab.idle_busy", 1, 32'(busy), 32'd0);
        // Abort during the slot-2 gap (cycles 21..24).
        code  = 14'h00E4;
        len   = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 22; c++) step();
        chk("ab.gap_key", 22, 32'(key), 32'd0);
        chk("ab.gap_busy", 22, 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab.err", 23, 32'(err), 32'd1);
        chk("ab.busy", 23, 32'(busy), 32'd0);
        chk("ab.done", 23, 32'(done), 32'd0);
        for (int c = 24; c < 44; c++) begin
            step();
            chk("ab.quiet_key", c, 32'(key), 32'd0);
            chk("ab.quiet_enter", c, 32'(enter), 32'd0);
            chk("ab.quiet_done", c, 32'(done), 32'd0);
            chk("ab.quiet_err", c, 32'(err), 32'd0);
        end
        // Start and abort together in idle: start wins.
        code  = 14'h00E4;
        len   = 4'd4;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("ab.race_busy", 1, 32'(busy), 32'd1);
        chk("ab.race_key", 1, 32'(key), 32'h1);
        chk("ab.race_err", 1, 32'(err), 32'd0);
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
